remote_cmd_tx: RTL and testbench
================================

Name: remote_cmd_tx

Overview:
- Initiator end of the two-byte command link: serialises a 16-bit command over UART as two bytes, high byte first, then waits for a single-byte response from the responder.
- Sits on the host/test side, opposite the command receiver in the target.
- Reuses the team's existing UART transceiver for bit-level framing.
- Adds command sequencing, a response-timeout watchdog and status flags.

Parameters:
- RESP_TIMEOUT, 1_000_000, clk cycles to wait for the response byte after the low byte completes. Counter width is $clog2(RESP_TIMEOUT).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- snd_cmd  in  1  request to send cmd; accepted only when idle
- cmd  in  16  command word, sampled on acceptance
- clr_resp_rdy  in  1  clears resp_rdy
- RX  in  1  serial in, from responder TX
- TX  out  1  serial out, to responder RX
- busy  out  1  high whenever state != IDLE
- cmd_snt  out  1  level; both bytes fully transmitted
- resp  out  8  last response byte received
- resp_rdy  out  1  level; resp holds a new byte
- timeout  out  1  level; no response within RESP_TIMEOUT

Behaviour:
- Reset: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: state=IDLE; busy=0, cmd_snt=0, resp=8'h00, resp_rdy=0, timeout=0, cmd_hold=0, timer=0. TX=1 (line idle; the UART guarantees this).
- tx_done from the UART is used only through a registered rising-edge detect (tx_done_rise), so level or pulse semantics both work.
- States:
  - IDLE: on snd_cmd, load cmd_hold<=cmd; clear cmd_snt, timeout and resp_rdy; go to SEND_HI. Otherwise stay.
  - SEND_HI: trmt=1 for exactly one cycle, tx_data=cmd_hold[15:8]; go to WAIT_HI.
  - WAIT_HI: on tx_done_rise, trmt=1 for one cycle, tx_data=cmd_hold[7:0]; go to WAIT_LO.
  - WAIT_LO: on tx_done_rise, set cmd_snt, clear timer; go to WAIT_RESP.
  - WAIT_RESP: on rx_rdy, resp<=rx_data, set resp_rdy, pulse clr_rx_rdy; go to IDLE. Else if timer==RESP_TIMEOUT-1, set timeout; go to IDLE. Else timer++.
- tx_data is a registered-select mux of cmd_hold. It is stable from the trmt cycle until the next trmt.
- Latency: trmt for the high byte is asserted the cycle after snd_cmd is accepted. The low byte's trmt is asserted the cycle after the high byte's tx_done rises. No idle gap between bytes beyond one clk.
- Boundaries and simultaneous events:
  - snd_cmd while busy: ignored; no queuing; cmd_hold unchanged.
  - rx_rdy and timer expiry in the same cycle: response wins; timeout stays 0.
  - clr_resp_rdy and resp capture in the same cycle: set wins.
  - rx_rdy in any state other than WAIT_RESP (stray or late byte): pulse clr_rx_rdy; discard the byte; resp and resp_rdy unchanged.
  - Response arriving after timeout: treated as stray.
  - rst_n asserted mid-byte: every register returns to its reset value immediately and the UART aborts its frame. The first snd_cmd after release sends a clean two-byte sequence.
  - RESP_TIMEOUT must be >= 2; enforced by an elaboration-time assertion.
- Outputs are registered except busy, which is decoded combinationally from the state register.

Decomposition:
- Package remote_cmd_pkg holds:
  - typedef enum logic [2:0] {IDLE, SEND_HI, WAIT_HI, WAIT_LO, WAIT_RESP} rc_state_t
  - localparam RESP_TIMEOUT_DEF = 1_000_000
- One sub-module: the existing UART transceiver, instance iUART, ports RX/TX/rx_rdy/clr_rx_rdy/rx_data/trmt/tx_data/tx_done.
- FSM, timer and flags live in this module; no further sub-modules.

Test Plan:
- Reset -> TX=1, busy=0, cmd_snt=0, resp_rdy=0, timeout=0, resp=8'h00.
- snd_cmd with cmd=16'hA5C3; the bench responder echoes 8'h5A after the second byte -> responder sees 0xA5 then 0xC3; cmd_snt rises at the second stop bit; resp=8'h5A, resp_rdy=1, busy=0, timeout=0.
- Send 16'h1234; during the high byte pulse snd_cmd with 16'hFFFF -> only 0x12, 0x34 appear on TX; cmd_hold unchanged.
- RESP_TIMEOUT=1000, responder silent, cmd=16'h0001 -> timeout=1 exactly 1000 cycles after cmd_snt rises; busy=0; resp_rdy=0. A late byte 0x77 is discarded and resp is unchanged.
- Stray byte 0x55 received while IDLE -> resp_rdy stays 0. The next command 16'hBEEF with response 0xAA yields resp=0xAA.
- rst_n pulsed mid high byte of 16'hDEAD -> all outputs return to reset values and TX=1. Then 16'h0F0F completes normally with bytes 0x0F, 0x0F.

Source files
------------

// File: rtl/remote_cmd_pkg.sv
// Shared types and defaults for the two-byte command link initiator.
package remote_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_HI,
    WAIT_HI,
    WAIT_LO,
    WAIT_RESP
  } rc_state_t;

  localparam int RESP_TIMEOUT_DEF = 1_000_000;
  localparam int BAUD_DIV_DEF     = 2604;

endpackage

// File: rtl/remote_cmd_tx_uart.sv
// 8N1 UART transceiver: one frame out on trmt, frames in flagged by rx_rdy.
module remote_cmd_tx_uart #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2);

  generate
    if (BAUD_DIV < 2) begin : g_bad_baud
      $error("BAUD_DIV must be at least 2");
    end
  endgenerate

  logic [9:0]    tx_shift_reg;
  logic [3:0]    tx_bits_reg;
  logic [BW-1:0] tx_baud_reg;
  logic          tx_busy_reg;
  logic          tx_done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift_reg <= '1;
      tx_bits_reg  <= '0;
      tx_baud_reg  <= '0;
      tx_busy_reg  <= 1'b0;
      tx_done_reg  <= 1'b0;
    end else if (trmt) begin
      tx_shift_reg <= {1'b1, tx_data, 1'b0};
      tx_bits_reg  <= '0;
      tx_baud_reg  <= '0;
      tx_busy_reg  <= 1'b1;
      tx_done_reg  <= 1'b0;
    end else if (tx_busy_reg) begin
      if (tx_baud_reg == BAUD_LAST) begin
        tx_baud_reg  <= '0;
        tx_shift_reg <= {1'b1, tx_shift_reg[9:1]};
        tx_bits_reg  <= tx_bits_reg + 4'd1;
        // tx_done rises at the end of the stop bit and stays until the next trmt
        if (tx_bits_reg == 4'd9) begin
          tx_busy_reg <= 1'b0;
          tx_done_reg <= 1'b1;
        end
      end else begin
        tx_baud_reg <= tx_baud_reg + BW'(1);
      end
    end
  end

  assign TX      = tx_shift_reg[0];
  assign tx_done = tx_done_reg;

  logic [1:0]    rx_sync_reg;
  logic          rx_line;
  logic          rx_busy_reg;
  logic [BW-1:0] rx_baud_reg;
  logic [3:0]    rx_bits_reg;
  logic [7:0]    rx_shift_reg;
  logic          rx_rdy_reg;

  assign rx_line = rx_sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_reg  <= 2'b11;
      rx_busy_reg  <= 1'b0;
      rx_baud_reg  <= '0;
      rx_bits_reg  <= '0;
      rx_shift_reg <= '0;
      rx_rdy_reg   <= 1'b0;
    end else begin
      rx_sync_reg <= {rx_sync_reg[0], RX};
      if (clr_rx_rdy) begin
        rx_rdy_reg <= 1'b0;
      end
      if (!rx_busy_reg) begin
        // Start half a bit in so every later sample lands mid-bit
        if (!rx_line) begin
          rx_busy_reg <= 1'b1;
          rx_baud_reg <= BAUD_HALF;
          rx_bits_reg <= '0;
        end
      end else if (rx_baud_reg == BAUD_LAST) begin
        rx_baud_reg <= '0;
        rx_bits_reg <= rx_bits_reg + 4'd1;
        if (rx_bits_reg == 4'd0) begin
          if (rx_line) begin
            rx_busy_reg <= 1'b0;
          end
        end else if (rx_bits_reg == 4'd9) begin
          rx_busy_reg <= 1'b0;
          if (rx_line) begin
            rx_rdy_reg <= 1'b1;
          end
        end else begin
          rx_shift_reg <= {rx_line, rx_shift_reg[7:1]};
        end
      end else begin
        rx_baud_reg <= rx_baud_reg + BW'(1);
      end
    end
  end

  assign rx_rdy  = rx_rdy_reg;
  assign rx_data = rx_shift_reg;

endmodule

// File: rtl/remote_cmd_tx.sv
// Command link initiator: sends a 16-bit command as two UART bytes (high first)
// and waits, with a watchdog, for a one-byte response.
module remote_cmd_tx
  import remote_cmd_pkg::*;
#(
  parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEF,
  parameter int BAUD_DIV     = BAUD_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  input  logic        clr_resp_rdy,
  input  logic        RX,
  output logic        TX,
  output logic        busy,
  output logic        cmd_snt,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  output logic        timeout
);

  localparam int TW = $clog2(RESP_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(RESP_TIMEOUT - 1);

  generate
    if (RESP_TIMEOUT < 2) begin : g_bad_timeout
      $error("RESP_TIMEOUT must be at least 2");
    end
  endgenerate

  rc_state_t     state_reg, state_next;
  logic [15:0]   cmd_hold_reg, cmd_hold_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          cmd_snt_reg, cmd_snt_next;
  logic [7:0]    resp_reg, resp_next;
  logic          resp_rdy_reg, resp_rdy_next;
  logic          timeout_reg, timeout_next;
  logic          tx_done_q_reg;

  logic       trmt;
  logic       use_lo;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       tx_done_rise;
  logic       rx_rdy;
  logic       clr_rx_rdy;
  logic [7:0] rx_data;

  remote_cmd_tx_uart #(
    .BAUD_DIV(BAUD_DIV)
  ) iUART (
    .clk       (clk),
    .rst_n     (rst_n),
    .RX        (RX),
    .TX        (TX),
    .rx_rdy    (rx_rdy),
    .clr_rx_rdy(clr_rx_rdy),
    .rx_data   (rx_data),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .tx_done   (tx_done)
  );

  assign tx_done_rise = tx_done & ~tx_done_q_reg;
  assign tx_data      = use_lo ? cmd_hold_reg[7:0] : cmd_hold_reg[15:8];
  assign busy         = (state_reg != IDLE);

  always_comb begin
    state_next    = state_reg;
    cmd_hold_next = cmd_hold_reg;
    timer_next    = timer_reg;
    cmd_snt_next  = cmd_snt_reg;
    resp_next     = resp_reg;
    resp_rdy_next = resp_rdy_reg & ~clr_resp_rdy;
    timeout_next  = timeout_reg;
    trmt          = 1'b0;
    use_lo        = 1'b1;
    // Every received byte is consumed; only WAIT_RESP keeps it
    clr_rx_rdy    = rx_rdy;
    case (state_reg)
      IDLE: begin
        if (snd_cmd) begin
          cmd_hold_next = cmd;
          cmd_snt_next  = 1'b0;
          timeout_next  = 1'b0;
          resp_rdy_next = 1'b0;
          state_next    = SEND_HI;
        end
      end
      SEND_HI: begin
        trmt       = 1'b1;
        use_lo     = 1'b0;
        state_next = WAIT_HI;
      end
      WAIT_HI: begin
        // High byte stays on tx_data until the low byte's trmt cycle
        if (tx_done_rise) begin
          trmt       = 1'b1;
          state_next = WAIT_LO;
        end else begin
          use_lo = 1'b0;
        end
      end
      WAIT_LO: begin
        if (tx_done_rise) begin
          cmd_snt_next = 1'b1;
          timer_next   = '0;
          state_next   = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (rx_rdy) begin
          resp_next     = rx_data;
          resp_rdy_next = 1'b1;
          state_next    = IDLE;
        end else if (timer_reg == TIMER_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cmd_hold_reg  <= '0;
      timer_reg     <= '0;
      cmd_snt_reg   <= 1'b0;
      resp_reg      <= 8'h00;
      resp_rdy_reg  <= 1'b0;
      timeout_reg   <= 1'b0;
      tx_done_q_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cmd_hold_reg  <= cmd_hold_next;
      timer_reg     <= timer_next;
      cmd_snt_reg   <= cmd_snt_next;
      resp_reg      <= resp_next;
      resp_rdy_reg  <= resp_rdy_next;
      timeout_reg   <= timeout_next;
      tx_done_q_reg <= tx_done;
    end
  end

  assign cmd_snt  = cmd_snt_reg;
  assign resp     = resp_reg;
  assign resp_rdy = resp_rdy_reg;
  assign timeout  = timeout_reg;

endmodule

// File: tb/tb_remote_cmd_tx.sv
// Directed bench for remote_cmd_tx with a bit-level responder model on TX/RX.
module tb_remote_cmd_tx;

  localparam int BAUD = 8;
  localparam int TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snd_cmd = 1'b0;
  logic [15:0] cmd = '0;
  logic        clr_resp_rdy = 1'b0;
  logic        RX = 1'b1;
  logic        TX;
  logic        busy;
  logic        cmd_snt;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        timeout;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stop_cyc = 0;
  logic [7:0] seen_q[$];

  remote_cmd_tx #(
    .RESP_TIMEOUT(TMO),
    .BAUD_DIV    (BAUD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .snd_cmd     (snd_cmd),
    .cmd         (cmd),
    .clr_resp_rdy(clr_resp_rdy),
    .RX          (RX),
    .TX          (TX),
    .busy        (busy),
    .cmd_snt     (cmd_snt),
    .resp        (resp),
    .resp_rdy    (resp_rdy),
    .timeout     (timeout)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Responder receive side: decodes every frame the DUT puts on TX
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && TX === 1'b0) begin
        logic [7:0] b;
        b = '0;
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = TX;
        end
        repeat (BAUD) @(negedge clk);
        stop_cyc = cyc;
        seen_q.push_back(b);
        $display("responder got byte %h at cycle %0d", b, cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [15:0] c);
    cmd = c;
    snd_cmd = 1'b1;
    tick(1);
    snd_cmd = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      tick(BAUD);
    end
    RX = 1'b1;
  endtask

  task automatic wait_cmd_snt();
    int n;
    n = 0;
    while (cmd_snt !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_resp_rdy();
    int n;
    n = 0;
    while (resp_rdy !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    total += 6;
    if (TX !== 1'b1) begin bad++; $display("FAIL reset_tx: TX=%b required 1", TX); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: busy=%b required 0", busy); end
    if (cmd_snt !== 1'b0) begin bad++; $display("FAIL reset_cmd_snt: cmd_snt=%b required 0", cmd_snt); end
    if (resp_rdy !== 1'b0) begin bad++; $display("FAIL reset_resp_rdy: resp_rdy=%b required 0", resp_rdy); end
    if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: timeout=%b required 0", timeout); end
    if (resp !== 8'h00) begin bad++; $display("FAIL reset_resp: resp=%h required 00", resp); end
    rst_n = 1'b1;
    tick(2);
    $display("test_reset done");
  endtask

  task automatic test_echo();
    int snt_cyc;
    seen_q.delete();
    send_cmd(16'hA5C3);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL echo_busy: busy=%b required 1", busy); end
    wait_cmd_snt();
    snt_cyc = cyc;
    total += 4;
    if (cmd_snt !== 1'b1) begin bad++; $display("FAIL echo_cmd_snt: cmd_snt=%b required 1", cmd_snt); end
    if (seen_q.size() != 2) begin bad++; $display("FAIL echo_count: %0d bytes seen, required 2", seen_q.size()); end
    else if (seen_q[0] !== 8'hA5 || seen_q[1] !== 8'hC3) begin
      bad++; $display("FAIL echo_bytes: got %h %h, required a5 c3", seen_q[0], seen_q[1]);
    end
    if (snt_cyc - stop_cyc < 1 || snt_cyc - stop_cyc > BAUD) begin
      bad++; $display("FAIL echo_snt_time: cmd_snt %0d cycles after stop sample, required 1..%0d", snt_cyc - stop_cyc, BAUD);
    end
    if (timeout !== 1'b0) begin bad++; $display("FAIL echo_timeout_mid: timeout=%b required 0", timeout); end
    send_rx(8'h5A);
    wait_resp_rdy();
    total += 4;
    if (resp !== 8'h5A) begin bad++; $display("FAIL echo_resp: resp=%h required 5a", resp); end
    if (resp_rdy !== 1'b1) begin bad++; $display("FAIL echo_resp_rdy: resp_rdy=%b required 1", resp_rdy); end
    if (busy !== 1'b0) begin bad++; $display("FAIL echo_busy_end: busy=%b required 0", busy); end
    if (timeout !== 1'b0) begin bad++; $display("FAIL echo_timeout: timeout=%b required 0", timeout); end
    clr_resp_rdy = 1'b1;
    tick(1);
    clr_resp_rdy = 1'b0;
    total++;
    if (resp_rdy !== 1'b0) begin bad++; $display("FAIL echo_clr: resp_rdy=%b required 0", resp_rdy); end
    $display("test_echo done: cmd a5c3 resp %h", resp);
  endtask

  task automatic test_busy_ignore();
    seen_q.delete();
    send_cmd(16'h1234);
    tick(20);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL ignore_busy: busy=%b required 1", busy); end
    send_cmd(16'hFFFF);
    wait_cmd_snt();
    total++;
    if (seen_q.size() != 2) begin bad++; $display("FAIL ignore_count: %0d bytes seen, required 2", seen_q.size()); end
    else if (seen_q[0] !== 8'h12 || seen_q[1] !== 8'h34) begin
      bad++; $display("FAIL ignore_bytes: got %h %h, required 12 34", seen_q[0], seen_q[1]);
    end
    send_rx(8'h11);
    wait_resp_rdy();
    tick(20 * BAUD);
    total += 2;
    if (resp !== 8'h11) begin bad++; $display("FAIL ignore_resp: resp=%h required 11", resp); end
    if (seen_q.size() != 2) begin bad++; $display("FAIL ignore_extra: %0d bytes seen, required 2", seen_q.size()); end
    $display("test_busy_ignore done: cmd 1234 resp %h", resp);
  endtask

  task automatic test_timeout();
    int n;
    seen_q.delete();
    send_cmd(16'h0001);
    wait_cmd_snt();
    n = 0;
    while (timeout !== 1'b1 && n < TMO + 100) begin
      tick(1);
      n++;
    end
    total += 5;
    if (n != TMO) begin bad++; $display("FAIL timeout_cycles: timeout after %0d cycles, required %0d", n, TMO); end
    if (timeout !== 1'b1) begin bad++; $display("FAIL timeout_flag: timeout=%b required 1", timeout); end
    if (busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: busy=%b required 0", busy); end
    if (resp_rdy !== 1'b0) begin bad++; $display("FAIL timeout_resp_rdy: resp_rdy=%b required 0", resp_rdy); end
    if (seen_q.size() != 2) begin bad++; $display("FAIL timeout_count: %0d bytes seen, required 2", seen_q.size()); end
    else if (seen_q[0] !== 8'h00 || seen_q[1] !== 8'h01) begin
      bad++; $display("FAIL timeout_bytes: got %h %h, required 00 01", seen_q[0], seen_q[1]);
    end
    send_rx(8'h77);
    tick(5);
    total += 2;
    if (resp !== 8'h11) begin bad++; $display("FAIL late_resp: resp=%h required 11", resp); end
    if (resp_rdy !== 1'b0) begin bad++; $display("FAIL late_resp_rdy: resp_rdy=%b required 0", resp_rdy); end
    $display("test_timeout done: timeout after %0d cycles", n);
  endtask

  task automatic test_stray();
    seen_q.delete();
    send_rx(8'h55);
    tick(5);
    total += 2;
    if (resp_rdy !== 1'b0) begin bad++; $display("FAIL stray_resp_rdy: resp_rdy=%b required 0", resp_rdy); end
    if (resp !== 8'h11) begin bad++; $display("FAIL stray_resp: resp=%h required 11", resp); end
    send_cmd(16'hBEEF);
    wait_cmd_snt();
    total++;
    if (seen_q.size() != 2) begin bad++; $display("FAIL stray_count: %0d bytes seen, required 2", seen_q.size()); end
    else if (seen_q[0] !== 8'hBE || seen_q[1] !== 8'hEF) begin
      bad++; $display("FAIL stray_bytes: got %h %h, required be ef", seen_q[0], seen_q[1]);
    end
    send_rx(8'hAA);
    wait_resp_rdy();
    total += 2;
    if (resp !== 8'hAA) begin bad++; $display("FAIL stray_next_resp: resp=%h required aa", resp); end
    if (resp_rdy !== 1'b1) begin bad++; $display("FAIL stray_next_rdy: resp_rdy=%b required 1", resp_rdy); end
    $display("test_stray done: cmd beef resp %h", resp);
  endtask

  task automatic test_reset_mid();
    seen_q.delete();
    send_cmd(16'hDEAD);
    tick(20);
    rst_n = 1'b0;
    #1;
    total += 6;
    if (TX !== 1'b1) begin bad++; $display("FAIL midrst_tx: TX=%b required 1", TX); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: busy=%b required 0", busy); end
    if (cmd_snt !== 1'b0) begin bad++; $display("FAIL midrst_cmd_snt: cmd_snt=%b required 0", cmd_snt); end
    if (resp !== 8'h00) begin bad++; $display("FAIL midrst_resp: resp=%h required 00", resp); end
    if (resp_rdy !== 1'b0) begin bad++; $display("FAIL midrst_resp_rdy: resp_rdy=%b required 0", resp_rdy); end
    if (timeout !== 1'b0) begin bad++; $display("FAIL midrst_timeout: timeout=%b required 0", timeout); end
    tick(3);
    rst_n = 1'b1;
    tick(15 * BAUD);
    seen_q.delete();
    send_cmd(16'h0F0F);
    wait_cmd_snt();
    total++;
    if (seen_q.size() != 2) begin bad++; $display("FAIL midrst_count: %0d bytes seen, required 2", seen_q.size()); end
    else if (seen_q[0] !== 8'h0F || seen_q[1] !== 8'h0F) begin
      bad++; $display("FAIL midrst_bytes: got %h %h, required 0f 0f", seen_q[0], seen_q[1]);
    end
    send_rx(8'h3C);
    wait_resp_rdy();
    total += 2;
    if (resp !== 8'h3C) begin bad++; $display("FAIL midrst_resp_after: resp=%h required 3c", resp); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy_after: busy=%b required 0", busy); end
    $display("test_reset_mid done: cmd 0f0f resp %h", resp);
  endtask

  initial begin
    test_reset();
    test_echo();
    test_busy_ignore();
    test_timeout();
    test_stray();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
